exec_mem_unit: RTL and testbench
================================

Name: exec_mem_unit

Overview:
Execute + memory/writeback stage directly downstream of the register file. Consumes the two register-read operands and a decoded micro-op (NOP/ADDI/ADD/SW) and computes the ALU result or store address. Performs word stores into a local data memory. Drives the register file write port (reg_wr, wr_addr, wr_din) two cycles after accepting an op, with internal operand forwarding so back-to-back dependent ops are correct.

Parameters:
DMEM_DEPTH, 16, number of 32-bit data-memory words (power of two)
DMEM_AW, 4, log2(DMEM_DEPTH); word index = address[DMEM_AW+1:2]

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  decoded op present this cycle
in_op  in  2  00 NOP, 01 ADDI, 10 ADD, 11 SW
in_rs1_addr  in  5  source-1 register index (for forwarding compare)
in_rs2_addr  in  5  source-2 register index
in_rs1_data  in  32  register file read data 1
in_rs2_data  in  32  register file read data 2
in_imm  in  12  immediate, sign-extended internally to 32 bits
in_rd  in  5  destination register index
stall  in  1  hazard-unit hold request
flush  in  1  kill the op in stage 1
in_ready  out  1  = !stall; op accepted on an edge with in_valid & in_ready
reg_wr  out  1  register file write enable (stage 2)
wr_addr  out  5  register file write index
wr_din  out  32  register file write data
store_err  out  1  one-cycle pulse: SW with misaligned address retired
dbg_addr  in  DMEM_AW  debug word index
dbg_data  out  32  combinational read of dmem[dbg_addr]

Behaviour:
- Pipeline: S1 (EX) register captures valid, op, rd, result, store data. S2 (WB) register captures S1. Accept at edge N; reg_wr/wr_addr/wr_din valid during cycle N+2 (from edge N+1 to edge N+2).
- Operand selection, combinational, per source x in {rs1, rs2}:
  - S1 valid, S1 op in {ADDI, ADD}, S1.rd != 0, S1.rd == in_rsx_addr: use S1.result.
  - Else same test against S2: use S2.result.
  - Else use in_rsx_data.
  - S1 has priority over S2. Source index 0 is never forwarded.
- Arithmetic (32-bit wrap, no overflow flag):
  - ADDI: rs1 + sext(imm).
  - ADD: rs1 + rs2.
  - SW: addr = rs1 + sext(imm); data = rs2.
  - NOP: result 0.
- Store: on the edge S1 advances into S2 with a valid SW:
  - addr[1:0] == 0: dmem[addr[DMEM_AW+1:2]] <= data. Upper address bits are ignored (wrap modulo depth).
  - addr[1:0] != 0: no write; store_err = 1 during the S2 cycle.
- Writeback: reg_wr = S2.valid & (S2.op in {ADDI, ADD}) & (S2.rd != 0). wr_addr = S2.rd and wr_din = S2.result whenever S2 is valid; both are 0 when S2 holds a bubble.
- Stall = 1:
  - No op accepted.
  - S1 holds its contents.
  - S2 loads a bubble, so reg_wr pulses exactly once per op.
  - No dmem write, because S1 is not advancing.
- Flush = 1: S1 loads a bubble on that edge. An op presented the same cycle is dropped. S2 advances normally. Flush overrides stall for S1.
- Reset (rst = 1 at an edge):
  - S1/S2 valid = 0; reg_wr = 0, wr_addr = 0, wr_din = 0, store_err = 0.
  - All dmem words = 0.
  - Reset mid-operation discards in-flight ops, including a pending SW.
  - Reset has priority over stall/flush.
- in_ready does not depend on in_valid (no combinational loop).
- dbg_data reflects a store starting the cycle after its write edge.

Test Plan:
- Reset: assert rst 2 cycles → reg_wr=0, wr_addr=0, wr_din=0, store_err=0; dbg_data=0 for every dbg_addr.
- ADDI basic: ADDI rd=3, rs1 data=5, imm=0xFFF (−1) accepted at edge N → during cycle N+2, reg_wr=1, wr_addr=3, wr_din=4; reg_wr=0 next cycle.
- Forwarding chain:
  - ADDI r1=r0+7, then ADD r2=r1+r1 next cycle (stale in_rs1_data=in_rs2_data=0) → wr_din=14 for r2.
  - Then ADD r4=r1+r2 on the following cycle → wr_din=21.
- Store: SW rs1 data=0x8, imm=4, rs2 data=0xDEADBEEF → dbg_addr=3 shows 0xDEADBEEF, reg_wr stays 0.
  - SW with address 0x6 → store_err pulses 1 cycle, dmem unchanged.
  - Address 0x44 with DMEM_DEPTH=16 → writes word 1.
- Stall/flush:
  - ADDI r5 held under stall for 3 cycles → exactly one reg_wr pulse, 2 cycles after stall drops.
  - ADDI r6 followed by flush in the next cycle → no write to r6.
  - rd=0 ADDI → reg_wr never asserts.
- Reset mid-flight: SW accepted, rst asserted the next cycle → dmem stays all-zero, no reg_wr or store_err.

Source files
------------

// File: rtl/exec_mem_unit.sv
// exec_mem_unit: execute + memory/writeback stage behind the register file.
// Two-stage pipeline (S1 = EX, S2 = WB) with forwarding from both stages,
// word stores into a small local data memory and a combinational debug port.
module exec_mem_unit #(
  parameter int DMEM_DEPTH = 16,
  parameter int DMEM_AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [1:0]         in_op,
  input  logic [4:0]         in_rs1_addr,
  input  logic [4:0]         in_rs2_addr,
  input  logic [31:0]        in_rs1_data,
  input  logic [31:0]        in_rs2_data,
  input  logic [11:0]        in_imm,
  input  logic [4:0]         in_rd,
  input  logic               stall,
  input  logic               flush,
  output logic               in_ready,
  output logic               reg_wr,
  output logic [4:0]         wr_addr,
  output logic [31:0]        wr_din,
  output logic               store_err,
  input  logic [DMEM_AW-1:0] dbg_addr,
  output logic [31:0]        dbg_data
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  // S1 (EX) state
  logic        s1_valid_reg;
  logic [1:0]  s1_op_reg;
  logic [4:0]  s1_rd_reg;
  logic [31:0] s1_result_reg;
  logic [31:0] s1_sdata_reg;

  // S2 (WB) state
  logic        s2_valid_reg;
  logic [1:0]  s2_op_reg;
  logic [4:0]  s2_rd_reg;
  logic [31:0] s2_result_reg;

  logic [31:0] dmem [DMEM_DEPTH];

  // Forwarding sources and selected operands, index 0 = rs1, 1 = rs2
  logic [4:0]  src_addr [2];
  logic [31:0] src_data [2];
  logic [31:0] opnd     [2];

  logic        s1_fwd;
  logic        s2_fwd;
  logic [31:0] imm_sext;
  logic [31:0] alu_result_next;
  logic [31:0] sdata_next;
  logic        s1_advance;
  logic        store_fire;
  logic [DMEM_AW-1:0] store_idx;

  assign in_ready = !stall;

  assign s1_fwd = s1_valid_reg && (s1_op_reg == OP_ADDI || s1_op_reg == OP_ADD) && (s1_rd_reg != 5'd0);
  assign s2_fwd = s2_valid_reg && (s2_op_reg == OP_ADDI || s2_op_reg == OP_ADD) && (s2_rd_reg != 5'd0);

  assign src_addr[0] = in_rs1_addr;
  assign src_addr[1] = in_rs2_addr;
  assign src_data[0] = in_rs1_data;
  assign src_data[1] = in_rs2_data;

  // Younger producer (S1) wins over older (S2); rd != 0 keeps r0 unforwarded
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign opnd[gi] = (s1_fwd && (s1_rd_reg == src_addr[gi])) ? s1_result_reg :
                      (s2_fwd && (s2_rd_reg == src_addr[gi])) ? s2_result_reg :
                      src_data[gi];
  end

  assign imm_sext = {{20{in_imm[11]}}, in_imm};

  // ALU: result (or store address) and store data for the incoming op
  always_comb begin
    alu_result_next = '0;
    sdata_next      = '0;
    case (in_op)
      OP_ADDI: alu_result_next = opnd[0] + imm_sext;
      OP_ADD:  alu_result_next = opnd[0] + opnd[1];
      OP_SW: begin
        alu_result_next = opnd[0] + imm_sext;
        sdata_next      = opnd[1];
      end
      default: alu_result_next = '0;
    endcase
  end

  // S1 contents move to S2 only when neither held nor killed
  assign s1_advance = !stall && !flush;
  assign store_idx  = s1_result_reg[DMEM_AW+1:2];
  assign store_fire = s1_advance && s1_valid_reg && (s1_op_reg == OP_SW) &&
                      (s1_result_reg[1:0] == 2'b00);

  // S1 register: bubble on flush, hold on stall, otherwise capture input
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_op_reg     <= OP_NOP;
      s1_rd_reg     <= '0;
      s1_result_reg <= '0;
      s1_sdata_reg  <= '0;
    end else if (flush) begin
      s1_valid_reg  <= 1'b0;
      s1_op_reg     <= OP_NOP;
      s1_rd_reg     <= '0;
      s1_result_reg <= '0;
      s1_sdata_reg  <= '0;
    end else if (!stall) begin
      s1_valid_reg  <= in_valid;
      s1_op_reg     <= in_op;
      s1_rd_reg     <= in_rd;
      s1_result_reg <= alu_result_next;
      s1_sdata_reg  <= sdata_next;
    end
  end

  // S2 register: takes S1 when it advances, a cleared bubble otherwise
  always_ff @(posedge clk) begin
    if (rst || !s1_advance || !s1_valid_reg) begin
      s2_valid_reg  <= 1'b0;
      s2_op_reg     <= OP_NOP;
      s2_rd_reg     <= '0;
      s2_result_reg <= '0;
    end else begin
      s2_valid_reg  <= 1'b1;
      s2_op_reg     <= s1_op_reg;
      s2_rd_reg     <= s1_rd_reg;
      s2_result_reg <= s1_result_reg;
    end
  end

  // Data memory: cleared by reset, written by an aligned SW leaving S1
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        dmem[i] <= '0;
      end
    end else if (store_fire) begin
      dmem[store_idx] <= s1_sdata_reg;
    end
  end

  assign dbg_data = dmem[dbg_addr];

  // S2 registers are zeroed on bubbles, so address/data need no extra gating
  assign reg_wr    = s2_fwd;
  assign wr_addr   = s2_rd_reg;
  assign wr_din    = s2_result_reg;
  assign store_err = s2_valid_reg && (s2_op_reg == OP_SW) && (s2_result_reg[1:0] != 2'b00);

endmodule

// File: tb/tb_exec_mem_unit.sv
// Testbench for exec_mem_unit: directed scenarios followed by random traffic,
// all checked against an in-order architectural model of registers and memory.
module tb_exec_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [4:0]  in_rs1_addr, in_rs2_addr;
  logic [31:0] in_rs1_data, in_rs2_data;
  logic [11:0] in_imm;
  logic [4:0]  in_rd;
  logic        stall, flush;
  logic        in_ready, reg_wr, store_err;
  logic [4:0]  wr_addr;
  logic [31:0] wr_din;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  exec_mem_unit #(.DMEM_DEPTH(16), .DMEM_AW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_rd(in_rd), .stall(stall), .flush(flush),
    .in_ready(in_ready), .reg_wr(reg_wr), .wr_addr(wr_addr), .wr_din(wr_din),
    .store_err(store_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Architectural model. arch = in-order register state of every op that has
  // left EX; rf_tb = external register file (updated when a write retires).
  typedef struct packed {
    bit          valid;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] sdata;
  } mop_t;

  logic [31:0] rf_tb [32];
  logic [31:0] arch  [32];
  logic [31:0] mem_m [16];
  mop_t pend;   // op accepted but not yet committed (may still be flushed)
  mop_t s2e;    // op expected on the writeback outputs this cycle

  function automatic bit is_writer(input mop_t m);
    return m.valid && (m.op == 2'b01 || m.op == 2'b10) && (m.rd != 5'd0);
  endfunction

  task automatic model_edge();
    mop_t n;
    logic [31:0] a, b, s;
    if (is_writer(s2e)) rf_tb[s2e.rd] = s2e.result;
    if (rst) begin
      pend = '0; s2e = '0;
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
    end else if (flush) begin
      pend = '0; s2e = '0;
    end else if (stall) begin
      s2e = '0;
    end else begin
      s2e = pend;
      if (is_writer(pend)) arch[pend.rd] = pend.result;
      if (pend.valid && pend.op == 2'b11 && pend.result[1:0] == 2'b00)
        mem_m[pend.result[5:2]] = pend.sdata;
      n = '0;
      if (in_valid) begin
        a = arch[in_rs1_addr];
        b = arch[in_rs2_addr];
        s = {{20{in_imm[11]}}, in_imm};
        n.valid = 1'b1; n.op = in_op; n.rd = in_rd;
        case (in_op)
          2'b01: n.result = a + s;
          2'b10: n.result = a + b;
          2'b11: begin n.result = a + s; n.sdata = b; end
          default: n.result = '0;
        endcase
      end
      pend = n;
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [1:0] op,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [11:0] imm, input logic [4:0] rd,
                       input bit st, input bit fl);
    rst = r; in_valid = v; in_op = op; in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rs1_data = rf_tb[rs1]; in_rs2_data = rf_tb[rs2];
    in_imm = imm; in_rd = rd; stall = st; flush = fl;
    dbg_addr = 4'($urandom_range(0, 15));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_val("reg_wr", reg_wr, is_writer(s2e));
    check_val("wr_addr", wr_addr, s2e.rd);
    check_val("wr_din", wr_din, s2e.result);
    check_val("store_err", store_err, s2e.valid && s2e.op == 2'b11 && s2e.result[1:0] != 2'b00);
    check_val("in_ready", in_ready, !st);
    check_val("dbg_data", dbg_data, mem_m[dbg_addr]);
    if (s2e.valid)
      $display("cyc %0d retire op=%0d rd=%0d result=%h reg_wr=%0b store_err=%0b",
               cyc, s2e.op, s2e.rd, wr_din, reg_wr, store_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic peek(input string tag, input logic [3:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check_val(tag, dbg_data, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_op = 0; in_rs1_addr = 0; in_rs2_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_rd = 0; stall = 0; flush = 0; dbg_addr = 0;
    for (int i = 0; i < 32; i++) rf_tb[i] = $urandom;
    rf_tb[0] = 0; rf_tb[9] = 5; rf_tb[10] = 32'h8; rf_tb[11] = 32'hDEADBEEF;
    rf_tb[12] = 32'h2; rf_tb[13] = 32'h40;
    for (int i = 0; i < 32; i++) arch[i] = rf_tb[i];
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    pend = '0; s2e = '0;

    // Reset and cleared memory
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) peek("dbg_after_rst", 4'(i), 32'h0);

    // ADDI r3 = r9(5) + (-1)
    cycle(0, 1, 2'b01, 9, 0, 12'hFFF, 3, 0, 0);
    idle(3);
    // Forwarding chain: r1 = 7, r2 = r1 + r1, r4 = r1 + r2
    cycle(0, 1, 2'b01, 0, 0, 12'd7, 1, 0, 0);
    cycle(0, 1, 2'b10, 1, 1, 0, 2, 0, 0);
    cycle(0, 1, 2'b10, 1, 2, 0, 4, 0, 0);
    idle(3);
    // Stores: aligned word 3, misaligned 0x6, wrapped 0x44 -> word 1
    cycle(0, 1, 2'b11, 10, 11, 12'd4, 0, 0, 0);
    idle(3);
    peek("sw_word3", 4'd3, 32'hDEADBEEF);
    cycle(0, 1, 2'b11, 12, 11, 12'd4, 0, 0, 0);
    idle(3);
    cycle(0, 1, 2'b11, 13, 11, 12'd4, 0, 0, 0);
    idle(3);
    peek("sw_wrap_word1", 4'd1, 32'hDEADBEEF);
    // Stall holds ADDI r5 for 3 cycles
    cycle(0, 1, 2'b01, 9, 0, 12'd1, 5, 0, 0);
    cycle(0, 1, 2'b01, 9, 0, 12'd2, 7, 1, 0);
    cycle(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    idle(3);
    // ADDI r6 killed by flush next cycle, then an rd=0 ADDI
    cycle(0, 1, 2'b01, 9, 0, 12'd3, 6, 0, 0);
    cycle(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    idle(2);
    cycle(0, 1, 2'b01, 9, 0, 12'd9, 0, 0, 0);
    idle(3);
    // Reset mid-flight discards a pending SW
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 2'b11, 10, 11, 12'd0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 16; i++) peek("dbg_midflight_rst", 4'(i), 32'h0);

    // Random traffic with hazards, stalls, flushes and occasional reset
    for (int t = 0; t < 500; t++) begin
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80,
            2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            12'($urandom), 5'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8);
    end
    idle(3);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
